// File: rtl/roach_reset_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : roach_reset_sequencer
// Purpose  : Sequenced reset controller for the sys_clk domain. Qualifies the
//            MMCM lock, holds the IDELAYCTRL in reset, waits for delay
//            calibration, then releases core and user resets in order.
//            Re-sequences on lock or ready loss and counts lock losses seen
//            while running.
// Options  : RST_SEQ_RETRY_EN - when defined, FAULT retries calibration after
//            RDY_TIMEOUT cycles instead of holding until sys_rst.
// Revision : 1.0 - initial release
// =============================================================================
module roach_reset_sequencer #(
   parameter int LOCK_WAIT         = 1024,
   parameter int IDELAY_RST_CYCLES = 16,
   parameter int RDY_TIMEOUT       = 4096,
   parameter int USER_DELAY        = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       mmcm_locked,
   input  logic       idelay_rdy,
   output logic       idelay_rst,
   output logic       rst_core,
   output logic       rst_user,
   output logic       seq_done,
   output logic       fault,
   output logic [7:0] lock_loss_count
);

   // The shared phase counter must hold the largest terminal value of any state.
   localparam int c_max_ab  = (LOCK_WAIT > IDELAY_RST_CYCLES) ? LOCK_WAIT : IDELAY_RST_CYCLES;
   localparam int c_max_cd  = (RDY_TIMEOUT > USER_DELAY) ? RDY_TIMEOUT : USER_DELAY;
   localparam int c_cnt_max = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   // Terminal counts. Timed states leave on their last cycle, so they compare
   // against N-1; lock qualification compares against the full LOCK_WAIT.
   localparam logic [c_cnt_w-1:0] c_lock_wait = c_cnt_w'(LOCK_WAIT);
   localparam logic [c_cnt_w-1:0] c_idly_last = c_cnt_w'(IDELAY_RST_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_rdy_last  = c_cnt_w'(RDY_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_user_last = c_cnt_w'(USER_DELAY - 1);
   localparam logic [7:0]         c_loss_max  = 8'hFF;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_IDLY_RST  = 3'd2,
      ST_IDLY_WAIT = 3'd3,
      ST_CORE_REL  = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAULT     = 3'd6
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [7:0]           r_loss_cnt;
   logic                 r_lock_meta;
   logic                 r_lock_s;
   logic                 r_rdy_meta;
   logic                 r_rdy_s;

   // Two-flop synchronisers bringing the asynchronous status inputs into sys_clk.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_rdy_meta  <= 1'b0;
         r_rdy_s     <= 1'b0;
      end else begin
         r_lock_meta <= mmcm_locked;
         r_lock_s    <= r_lock_meta;
         r_rdy_meta  <= idelay_rdy;
         r_rdy_s     <= r_rdy_meta;
      end
   end

   // Sequencing FSM: state, shared phase counter, lock-loss counter and the
   // output decode registered one cycle behind the state.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state         <= ST_RESET;
         r_cnt           <= '0;
         r_loss_cnt      <= 8'd0;
         idelay_rst      <= 1'b1;
         rst_core        <= 1'b1;
         rst_user        <= 1'b1;
         seq_done        <= 1'b0;
         fault           <= 1'b0;
         lock_loss_count <= 8'd0;
      end else begin
         // Outputs follow the state the FSM occupied during this cycle.
         idelay_rst      <= (r_state == ST_RESET)     || (r_state == ST_WAIT_LOCK) ||
                            (r_state == ST_IDLY_RST)  || (r_state == ST_FAULT);
         rst_core        <= !((r_state == ST_CORE_REL) || (r_state == ST_RUN));
         rst_user        <= (r_state != ST_RUN);
         seq_done        <= (r_state == ST_RUN);
         fault           <= (r_state == ST_FAULT);
         lock_loss_count <= r_loss_cnt;

         case (r_state)
            ST_RESET: begin
               r_state <= ST_WAIT_LOCK;
               r_cnt   <= '0;
            end

            // Lock must be seen high continuously; any low sample restarts it.
            ST_WAIT_LOCK: begin
               if (!r_lock_s) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_lock_wait) begin
                  r_state <= ST_IDLY_RST;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_IDLY_RST: begin
               if (!r_lock_s) begin
                  r_state <= ST_WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (r_cnt == c_idly_last) begin
                  r_state <= ST_IDLY_WAIT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // Lock loss outranks ready; ready outranks the calibration timeout.
            ST_IDLY_WAIT: begin
               if (!r_lock_s) begin
                  r_state <= ST_WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (r_rdy_s) begin
                  r_state <= ST_CORE_REL;
                  r_cnt   <= '0;
               end else if (r_cnt == c_rdy_last) begin
                  r_state <= ST_FAULT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_CORE_REL: begin
               if (!r_lock_s) begin
                  r_state <= ST_WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (!r_rdy_s) begin
                  r_state <= ST_IDLY_RST;
                  r_cnt   <= '0;
               end else if (r_cnt == c_user_last) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // Only lock losses taken from RUN are counted for software.
            ST_RUN: begin
               r_cnt <= '0;
               if (!r_lock_s) begin
                  r_state <= ST_WAIT_LOCK;
                  if (r_loss_cnt != c_loss_max) begin
                     r_loss_cnt <= r_loss_cnt + 8'd1;
                  end
               end else if (!r_rdy_s) begin
                  r_state <= ST_IDLY_RST;
               end
            end

            ST_FAULT: begin
`ifdef RST_SEQ_RETRY_EN
               // Back off for one timeout period, then retry calibration.
               if (r_cnt == c_rdy_last) begin
                  r_state <= ST_IDLY_RST;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`else
               // Sticky until sys_rst.
               r_cnt <= '0;
`endif
            end

            default: begin
               r_state <= ST_RESET;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_roach_reset_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_roach_reset_sequencer
// Purpose  : Self-checking bench for roach_reset_sequencer. A phase/age model
//            derived from the sequencing rules predicts every output each
//            cycle; directed scenarios pin key latencies with literal values,
//            followed by a randomized soak.
// Options  : RST_SEQ_RETRY_EN - selects the retrying FAULT behaviour.
// Revision : 1.0 - initial release
// =============================================================================
module tb_roach_reset_sequencer;

   localparam int LW  = 16;
   localparam int IRC = 8;
   localparam int RT  = 64;
   localparam int UD  = 4;

   localparam int P_RESET     = 0;
   localparam int P_WAIT_LOCK = 1;
   localparam int P_IDLY_RST  = 2;
   localparam int P_IDLY_WAIT = 3;
   localparam int P_CORE_REL  = 4;
   localparam int P_RUN       = 5;
   localparam int P_FAULT     = 6;

   logic       clk;
   logic       sys_rst;
   logic       mmcm_locked;
   logic       idelay_rdy;
   logic       idelay_rst;
   logic       rst_core;
   logic       rst_user;
   logic       seq_done;
   logic       fault;
   logic [7:0] lock_loss_count;

   roach_reset_sequencer #(
      .LOCK_WAIT         (LW),
      .IDELAY_RST_CYCLES (IRC),
      .RDY_TIMEOUT       (RT),
      .USER_DELAY        (UD)
   ) dut (
      .sys_clk         (clk),
      .sys_rst         (sys_rst),
      .mmcm_locked     (mmcm_locked),
      .idelay_rdy      (idelay_rdy),
      .idelay_rst      (idelay_rst),
      .rst_core        (rst_core),
      .rst_user        (rst_user),
      .seq_done        (seq_done),
      .fault           (fault),
      .lock_loss_count (lock_loss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: current phase, edges spent in it, lock run length,
   // loss count, raw input history and edges since the last reset.
   int         ph;
   int         age;
   int         lock_run;
   int         loss;
   int         quiet;
   int         cyc;
   logic       lk_h0, lk_h1, rd_h0, rd_h1;
   bit         m_valid;
   logic       e_idelay, e_core, e_user, e_done, e_fault;
   logic [7:0] e_cnt;

   int n_vec;
   int n_bad;

   int t_ref, e_at, g_at, h_at;

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Advance the model by one rising edge using the inputs sampled there.
   task automatic model_edge();
      logic ls, rs;
      int   nxt;
      cyc++;
      if (sys_rst) begin
         e_idelay = 1'b1; e_core = 1'b1; e_user = 1'b1;
         e_done   = 1'b0; e_fault = 1'b0; e_cnt = 8'd0;
         m_valid  = 1'b1;
      end else begin
         e_idelay = (ph == P_RESET) || (ph == P_WAIT_LOCK) || (ph == P_IDLY_RST) || (ph == P_FAULT);
         e_core   = !((ph == P_CORE_REL) || (ph == P_RUN));
         e_user   = (ph != P_RUN);
         e_done   = (ph == P_RUN);
         e_fault  = (ph == P_FAULT);
         e_cnt    = loss[7:0];
      end
      // Synchronised view: the raw sample from two edges ago, zero if a reset
      // hit either synchroniser stage since then.
      ls = (quiet >= 2) ? lk_h1 : 1'b0;
      rs = (quiet >= 2) ? rd_h1 : 1'b0;
      lock_run = ls ? min2(lock_run + 1, 1000000) : 0;
      if (sys_rst) begin
         ph   = P_RESET;
         age  = 0;
         loss = 0;
      end else begin
         nxt = ph;
         case (ph)
            P_RESET:     nxt = P_WAIT_LOCK;
            P_WAIT_LOCK: if (min2(lock_run, age + 1) >= LW + 1) nxt = P_IDLY_RST;
            P_IDLY_RST: begin
               if (!ls) nxt = P_WAIT_LOCK;
               else if (age == IRC - 1) nxt = P_IDLY_WAIT;
            end
            P_IDLY_WAIT: begin
               if (!ls) nxt = P_WAIT_LOCK;
               else if (rs) nxt = P_CORE_REL;
               else if (age == RT - 1) nxt = P_FAULT;
            end
            P_CORE_REL: begin
               if (!ls) nxt = P_WAIT_LOCK;
               else if (!rs) nxt = P_IDLY_RST;
               else if (age == UD - 1) nxt = P_RUN;
            end
            P_RUN: begin
               if (!ls) begin
                  nxt  = P_WAIT_LOCK;
                  loss = min2(loss + 1, 255);
               end else if (!rs) begin
                  nxt = P_IDLY_RST;
               end
            end
            P_FAULT: begin
`ifdef RST_SEQ_RETRY_EN
               if (age == RT - 1) nxt = P_IDLY_RST;
`endif
            end
            default: nxt = P_RESET;
         endcase
         age = (nxt != ph) ? 0 : age + 1;
         ph  = nxt;
      end
      lk_h1 = lk_h0; lk_h0 = mmcm_locked;
      rd_h1 = rd_h0; rd_h0 = idelay_rdy;
      quiet = sys_rst ? 0 : min2(quiet + 1, 3);
   endtask

   task automatic cmp1(input string nm, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // One clock: update the model at the rising edge, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_valid) begin
         n_vec++;
         cmp1("idelay_rst",      {7'd0, idelay_rst}, {7'd0, e_idelay});
         cmp1("rst_core",        {7'd0, rst_core},   {7'd0, e_core});
         cmp1("rst_user",        {7'd0, rst_user},   {7'd0, e_user});
         cmp1("seq_done",        {7'd0, seq_done},   {7'd0, e_done});
         cmp1("fault",           {7'd0, fault},      {7'd0, e_fault});
         cmp1("lock_loss_count", lock_loss_count,    e_cnt);
      end
   endtask

   task automatic check_lit(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic out_sel(input int sel);
      case (sel)
         0:       return idelay_rst;
         1:       return rst_core;
         2:       return rst_user;
         3:       return seq_done;
         4:       return fault;
         default: return 1'b0;
      endcase
   endfunction

   // Step until the selected output reaches val; edge_at = edge it changed on.
   task automatic wait_for(input string nm, input int sel, input logic val,
                           input int budget, output int edge_at);
      bit found;
      found   = 1'b0;
      edge_at = -1;
      for (int i = 0; i < budget && !found; i++) begin
         step();
         if (out_sel(sel) === val) begin
            found   = 1'b1;
            edge_at = cyc;
         end
      end
      if (!found) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: no transition to %0b within %0d cycles", nm, val, budget);
      end
   endtask

   task automatic do_reset(input int n);
      sys_rst = 1'b1;
      repeat (n) step();
      sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1; mmcm_locked = 1'b0; idelay_rdy = 1'b0;
      ph = P_RESET; age = 0; lock_run = 0; loss = 0; quiet = 0; cyc = 0;
      lk_h0 = 0; lk_h1 = 0; rd_h0 = 0; rd_h1 = 0; m_valid = 0;
      e_idelay = 1; e_core = 1; e_user = 1; e_done = 0; e_fault = 0; e_cnt = 0;
      n_vec = 0; n_bad = 0;

      // Reset state.
      do_reset(3);
      check_lit("reset idelay_rst", int'(idelay_rst), 1);
      check_lit("reset rst_core",   int'(rst_core),   1);
      check_lit("reset rst_user",   int'(rst_user),   1);
      check_lit("reset seq_done",   int'(seq_done),   0);
      check_lit("reset fault",      int'(fault),      0);
      check_lit("reset count",      int'(lock_loss_count), 0);

      // Clean bring-up: lock at cycle 10, ready 5 cycles after idelay_rst falls.
      repeat (10) step();
      mmcm_locked = 1'b1; t_ref = cyc + 1;
      wait_for("bringup idelay_rst fall", 0, 1'b0, 200, e_at);
      check_lit("bringup lock to idelay_rst release", e_at - t_ref, 27);
      repeat (4) step();
      idelay_rdy = 1'b1; t_ref = cyc + 1;
      check_lit("bringup rdy offset", t_ref - e_at, 5);
      wait_for("bringup rst_core fall", 1, 1'b0, 50, e_at);
      check_lit("bringup rdy to rst_core", e_at - t_ref, 3);
      wait_for("bringup rst_user fall", 2, 1'b0, 50, e_at);
      check_lit("bringup rdy to rst_user", e_at - t_ref, 7);
      check_lit("bringup seq_done", int'(seq_done), 1);
      check_lit("bringup count", int'(lock_loss_count), 0);

      // Repeated lock loss in RUN; count saturates.
      for (int i = 0; i < 300; i++) begin
         mmcm_locked = 1'b0; t_ref = cyc + 1;
         wait_for("loss rst_core rise", 1, 1'b1, 20, e_at);
         if (e_at < 0) break;
         check_lit("loss reassert latency", e_at - t_ref, 3);
         check_lit("loss count", int'(lock_loss_count), min2(i + 1, 255));
         check_lit("loss seq_done low", int'(seq_done), 0);
         repeat ($urandom_range(0, 3)) step();
         mmcm_locked = 1'b1;
         wait_for("relock seq_done", 3, 1'b1, 120, e_at);
         if (e_at < 0) break;
      end
      check_lit("loss count saturated", int'(lock_loss_count), 255);

      // Lock glitch during qualification restarts it.
      do_reset(2);
      mmcm_locked = 1'b0; idelay_rdy = 1'b0;
      repeat (5) step();
      mmcm_locked = 1'b1;
      repeat (10) step();
      mmcm_locked = 1'b0;
      step();
      mmcm_locked = 1'b1; t_ref = cyc + 1;
      wait_for("glitch idelay_rst fall", 0, 1'b0, 200, e_at);
      check_lit("glitch requalify latency", e_at - t_ref, 27);
      idelay_rdy = 1'b1;
      wait_for("glitch seq_done", 3, 1'b1, 50, e_at);

      // Simultaneous lock and ready drop in RUN: lock loss wins.
      mmcm_locked = 1'b0; idelay_rdy = 1'b0; t_ref = cyc + 1;
      wait_for("dual drop rst_core rise", 1, 1'b1, 20, e_at);
      check_lit("dual drop latency", e_at - t_ref, 3);
      check_lit("dual drop count", int'(lock_loss_count), 1);
      repeat (3) step();
      mmcm_locked = 1'b1; idelay_rdy = 1'b1;
      wait_for("dual drop relock", 3, 1'b1, 120, e_at);

      // Ready drop back to IDLY_RST, then sys_rst in the middle of CORE_REL.
      idelay_rdy = 1'b0;
      wait_for("rdy drop rst_core rise", 1, 1'b1, 20, e_at);
      idelay_rdy = 1'b1;
      wait_for("core_rel entry", 1, 1'b0, 60, e_at);
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      check_lit("midrst idelay_rst", int'(idelay_rst), 1);
      check_lit("midrst rst_core",   int'(rst_core),   1);
      check_lit("midrst rst_user",   int'(rst_user),   1);
      check_lit("midrst seq_done",   int'(seq_done),   0);
      check_lit("midrst count",      int'(lock_loss_count), 0);

      // Ready never arrives: calibration timeout.
      do_reset(2);
      mmcm_locked = 1'b1; idelay_rdy = 1'b0;
      wait_for("timeout idelay_rst fall", 0, 1'b0, 200, e_at);
      wait_for("timeout fault rise", 4, 1'b1, 200, g_at);
      check_lit("timeout fault latency", g_at - e_at, 64);
      check_lit("timeout idelay_rst", int'(idelay_rst), 1);
      check_lit("timeout rst_core",   int'(rst_core),   1);
      check_lit("timeout rst_user",   int'(rst_user),   1);
`ifdef RST_SEQ_RETRY_EN
      wait_for("retry fault clear", 4, 1'b0, 200, h_at);
      check_lit("retry fault duration", h_at - g_at, 64);
      wait_for("retry idelay_rst fall", 0, 1'b0, 100, h_at);
      check_lit("retry idelay_rst release", h_at - g_at, 72);
`else
      repeat (150) step();
      check_lit("sticky fault", int'(fault), 1);
`endif

      // Randomized soak with occasional resets.
      do_reset(2);
      mmcm_locked = 1'b1; idelay_rdy = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) mmcm_locked = !mmcm_locked;
         if ($urandom_range(0, 29) == 0) idelay_rdy  = !idelay_rdy;
         sys_rst = ($urandom_range(0, 399) == 0);
         step();
      end
      sys_rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
